traffic_lights: RTL and testbench
=================================

# traffic_lights

Highway/farm-road intersection controller. The highway has priority and stays green until a car sensor on the farm road requests service. The block then steps through yellow, all-red and farm-green phases, and returns to highway green once the farm road is empty. It is a single-clock Moore FSM with cycle-count phase timers, driving two 2-bit light codes to the lamp drivers.

## Interface
Parameters:
- `Y2R_DELAY`, default 3: clock cycles spent in each yellow phase (highway yellow and farm yellow). Legal range is 1 or more.
- `R2G_DELAY`, default 2: clock cycles spent in the all-red phase before farm green. Legal range is 1 or more.

Light encoding, fixed:
- RED = 2'b00
- YELLOW = 2'b01
- GREEN = 2'b10
- 2'b11 is never driven.

The source file defines the text macros `` `TRUE `` (1'b1) and `` `FALSE `` (1'b0) at file scope, guarded by `` `ifndef ``. Benches compiled after this file use them.

Ports, in this positional order: highway, farm, x, clk, clear.
- `clk` input, 1 bit: the single clock. All state changes happen on its rising edge.
- `clear` input, 1 bit: reset. Reset is synchronous and active-high.
- `highway` output, 2 bits: highway light code.
- `farm` output, 2 bits: farm-road light code.
- `x` input, 1 bit: farm-road car sensor. 1 means a car is present. It is sampled on rising edges of `clk`.

## Operation
States, with (highway, farm) outputs:
- S0: (GREEN, RED). Reset state.
- S1: (YELLOW, RED).
- S2: (RED, RED).
- S3: (RED, GREEN).
- S4: (RED, YELLOW).

Transitions, all evaluated at the rising edge of `clk`:
- S0 to S1 when `x`=1. Stay in S0 while `x`=0.
- S1 to S2 after exactly Y2R_DELAY cycles in S1, regardless of `x`.
- S2 to S3 after exactly R2G_DELAY cycles in S2, regardless of `x`.
- S3 stays in S3 while `x`=1. S3 to S4 on the first edge where `x`=0.
- S4 to S0 after exactly Y2R_DELAY cycles in S4, regardless of `x`.

Timer:
- One down- or up-counter, sized for max(Y2R_DELAY, R2G_DELAY).
- It is loaded or cleared on every state change.
- A timed state is occupied for exactly its DELAY count of clock cycles. With DELAY=1 the state lasts one cycle.
- The counter is don't-care in S0 and S3 but must not affect transitions there.

Outputs are a pure decode of the state register (Moore). There is no decode from `x` to outputs.

Boundary behaviour:
- `x` glitches during S1, S2 or S4 are ignored. The sequence always completes.
- `x`=1 when S4 finishes: the block still enters S0 and shows highway GREEN for at least one cycle. It then goes to S1 on the next edge.
- `x`=1 for a single cycle in S0 is enough to start the full sequence.
- `clear`=1 at any edge, mid-sequence included, forces S0 and clears the timer. Outputs become (GREEN, RED) after that edge.
- `clear` has priority over all transitions.
- Unreachable state encodings recover to S0 on the next edge.
- Outputs are undefined before the first edge with `clear`=1.

## Timing
- Reset value of the outputs: `highway`=2'b10, `farm`=2'b00, valid after the first rising edge with `clear`=1.
- Outputs change only just after rising edges of `clk`. There is no combinational path from inputs to outputs.
- Latency from `x`=1 sampled at edge N in S0 (default parameters):
  - highway YELLOW during cycles N..N+2.
  - all-red during N+3..N+4.
  - farm GREEN from edge N+5.
- Exit from farm green: `x`=0 sampled at edge M in S3 gives farm YELLOW during M..M+2, then highway GREEN from edge M+3.
- Minimum farm-green hold is one cycle.
- The sequence S1 through S4 takes 2×Y2R_DELAY + R2G_DELAY + (cycles in S3).

## Test plan
- Hold `clear`=1 for 5 cycles with `x`=0. Outputs must be `highway`=10, `farm`=00 throughout. Release `clear` and keep `x`=0 for 20 cycles; outputs must stay 10/00.
- Raise `x` for 10 cycles (100 time units at a 10-unit clock), then drop it. Required sequence:
  - 01/00 for 3 cycles,
  - 00/00 for 2 cycles,
  - 00/10 until `x`=0 is sampled,
  - 00/01 for 3 cycles,
  - back to 10/00.
- Pulse `x` high for one cycle in S0. The full sequence must run, with farm green lasting exactly one cycle before farm yellow.
- Toggle `x` during S1, S2 and S4. Phase lengths must stay 3/2/3 cycles.
- Assert `clear` for one cycle during S2 and again during S3. Outputs must be 10/00 on the next edge, and the block must idle in S0 while `x`=0.
- Repeat the `x` request three times, each preceded by 20 idle cycles. Each cycle must reproduce identical phase durations, with no 2'b11 code ever appearing on either output.

Source files
------------

// File: rtl/traffic_lights.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_lights
//  Purpose  : Highway/farm-road intersection controller. Highway green by
//             default; a farm-road car request runs yellow, all-red and
//             farm-green phases, then farm yellow back to highway green.
//             Moore FSM with a single shared phase timer.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef TRUE
`define TRUE  1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif

module traffic_lights #(
    parameter int Y2R_DELAY = 3,   // cycles in each yellow phase (>= 1)
    parameter int R2G_DELAY = 2    // cycles in the all-red phase (>= 1)
) (
    output logic [1:0] highway,
    output logic [1:0] farm,
    input  logic       x,
    input  logic       clk,
    input  logic       clear
);

    localparam logic [1:0] c_RED    = 2'b00;
    localparam logic [1:0] c_YELLOW = 2'b01;
    localparam logic [1:0] c_GREEN  = 2'b10;

    localparam int c_MAX_DELAY = (Y2R_DELAY > R2G_DELAY) ? Y2R_DELAY : R2G_DELAY;
    // Timer counts down from DELAY-1 to 0, so it only needs to hold MAX-1.
    localparam int c_CNT_W     = (c_MAX_DELAY > 1) ? $clog2(c_MAX_DELAY) : 1;

    localparam logic [c_CNT_W-1:0] c_Y2R_LOAD = c_CNT_W'(Y2R_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_R2G_LOAD = c_CNT_W'(R2G_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S0 = 3'd0,   // highway green, farm red
        S1 = 3'd1,   // highway yellow, farm red
        S2 = 3'd2,   // all red
        S3 = 3'd3,   // highway red, farm green
        S4 = 3'd4    // highway red, farm yellow
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   timer_q, timer_d;

    // State and phase-timer registers; clear forces highway green and zeroes the timer.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next-state and timer: timed phases load DELAY-1 on entry and leave when the timer hits 0.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S0: begin
                if (x) begin
                    state_d = S1;
                    timer_d = c_Y2R_LOAD;
                end
            end
            S1: begin
                if (timer_q == '0) begin
                    state_d = S2;
                    timer_d = c_R2G_LOAD;
                end else begin
                    timer_d = timer_q - c_CNT_ONE;
                end
            end
            S2: begin
                if (timer_q == '0) begin
                    state_d = S3;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - c_CNT_ONE;
                end
            end
            S3: begin
                if (!x) begin
                    state_d = S4;
                    timer_d = c_Y2R_LOAD;
                end
            end
            S4: begin
                if (timer_q == '0) begin
                    state_d = S0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - c_CNT_ONE;
                end
            end
            default: begin
                // Unused encodings fall back to highway green.
                state_d = S0;
                timer_d = '0;
            end
        endcase
    end

    // Lamp codes decoded purely from the state register.
    always_comb begin
        highway = c_RED;
        farm    = c_RED;
        case (state_q)
            S0: begin
                highway = c_GREEN;
                farm    = c_RED;
            end
            S1: begin
                highway = c_YELLOW;
                farm    = c_RED;
            end
            S2: begin
                highway = c_RED;
                farm    = c_RED;
            end
            S3: begin
                highway = c_RED;
                farm    = c_GREEN;
            end
            S4: begin
                highway = c_RED;
                farm    = c_YELLOW;
            end
            default: begin
                highway = c_RED;
                farm    = c_RED;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_traffic_lights.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_lights
//  Purpose  : Directed self-checking bench for traffic_lights with default
//             delays (yellow 3, all-red 2). Observed value is {highway, farm}.
//  Revision : 1.0  initial release
// ============================================================================

module tb_traffic_lights;

    // {highway, farm} codes
    localparam logic [3:0] c_HG_FR = 4'b1000;
    localparam logic [3:0] c_HY_FR = 4'b0100;
    localparam logic [3:0] c_HR_FR = 4'b0000;
    localparam logic [3:0] c_HR_FG = 4'b0010;
    localparam logic [3:0] c_HR_FY = 4'b0001;

    logic       clk;
    logic       clear;
    logic       x;
    logic [1:0] highway;
    logic [1:0] farm;

    int n_checks = 0;
    int n_errors = 0;

    traffic_lights #(
        .Y2R_DELAY (3),
        .R2G_DELAY (2)
    ) u_dut (
        .highway (highway),
        .farm    (farm),
        .x       (x),
        .clk     (clk),
        .clear   (clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        x = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            check("idle", {highway, farm}, c_HG_FR);
        end
    endtask

    // One full request from S0. mode 0: x held high into farm green,
    // mode 1: single-cycle pulse, mode 2: x toggling in timed phases.
    // g = number of farm-green cycles observed.
    task automatic run_request(input int mode, input int g);
        x = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            check("hwy_yellow", {highway, farm}, c_HY_FR);
            x = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : (i % 2 == 1);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            check("all_red", {highway, farm}, c_HR_FR);
            x = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : (i % 2 == 0);
            step();
        end
        for (int i = 0; i < g; i++) begin
            check("farm_green", {highway, farm}, c_HR_FG);
            x = (i < g - 1);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            check("farm_yellow", {highway, farm}, c_HR_FY);
            x = (mode == 2) ? (i < 2) : 1'b0;
            step();
        end
        x = 1'b0;
        check("back_s0", {highway, farm}, c_HG_FR);
    endtask

    initial begin
        x     = 1'b0;
        clear = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset", {highway, farm}, c_HG_FR);
        end
        clear = 1'b0;
        idle(20);

        // x high for 10 edges: 3 yellow, 2 red, 5 green, 3 farm yellow
        run_request(0, 5);
        idle(3);

        // single-cycle pulse, one-cycle farm green
        run_request(1, 1);
        idle(2);

        // x glitches in S1/S2/S4 must not change phase lengths
        run_request(2, 2);
        idle(2);

        // x high as S4 finishes: one cycle of highway green, then yellow
        x = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        check("s3_hold", {highway, farm}, c_HR_FG);
        x = 1'b0;
        step();
        check("s4_entry", {highway, farm}, c_HR_FY);
        step();
        step();
        x = 1'b1;
        step();
        check("s0_min_green", {highway, farm}, c_HG_FR);
        step();
        check("s0_to_s1", {highway, farm}, c_HY_FR);
        clear = 1'b1;
        x     = 1'b0;
        step();
        check("clear_in_s1", {highway, farm}, c_HG_FR);
        clear = 1'b0;
        idle(3);

        // clear during S2
        x = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("in_s2", {highway, farm}, c_HR_FR);
        clear = 1'b1;
        x     = 1'b0;
        step();
        check("clear_in_s2", {highway, farm}, c_HG_FR);
        clear = 1'b0;
        idle(5);

        // clear during S3 while x is still high: clear wins
        x = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("in_s3", {highway, farm}, c_HR_FG);
        clear = 1'b1;
        step();
        check("clear_in_s3", {highway, farm}, c_HG_FR);
        clear = 1'b0;
        idle(5);

        // repeated requests reproduce the same phase lengths
        for (int k = 0; k < 3; k++) begin
            idle(20);
            run_request(0, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
